// File: rtl/memory_stage.sv
// MEM stage: data-memory request/response handshake, store lane steering, load extension
// and the MEM/WB pipeline register.
module memory_stage #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 10,
  parameter int unsigned DMEM_ADDR_WIDTH = 12
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [DATA_WIDTH-1:0]      i_alu_result_m,
  input  logic [DATA_WIDTH-1:0]      i_write_data_m,
  input  logic                       i_regwrite_m,
  input  logic                       i_memwrite_m,
  input  logic [1:0]                 i_resultsrc_m,
  input  logic [4:0]                 i_rd_addr_m,
  input  logic [ADDR_WIDTH-1:0]      i_pc4_m,
  input  logic [2:0]                 i_f3_m,
  output logic                       o_dmem_req,
  output logic                       o_dmem_we,
  output logic [DMEM_ADDR_WIDTH-1:0] o_dmem_addr,
  output logic [3:0]                 o_dmem_be,
  output logic [DATA_WIDTH-1:0]      o_dmem_wdata,
  input  logic                       i_dmem_rvalid,
  input  logic [DATA_WIDTH-1:0]      i_dmem_rdata,
  output logic                       o_stall_m,
  output logic [DATA_WIDTH-1:0]      o_forward_m,
  output logic                       o_regwrite_w,
  output logic [1:0]                 o_resultsrc_w,
  output logic [4:0]                 o_rd_addr_w,
  output logic [DATA_WIDTH-1:0]      o_alu_result_w,
  output logic [DATA_WIDTH-1:0]      o_read_data_w,
  output logic [ADDR_WIDTH-1:0]      o_pc4_w,
  output logic                       o_misaligned_w
);

  typedef enum logic {StIdle, StWait} state_e;

  state_e state_q, state_d;

  logic                  access, is_load, is_store, misaligned, aligned_access;
  logic [1:0]            byte_off;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] load_ext;

  assign is_store       = i_memwrite_m;
  assign is_load        = (i_resultsrc_m == 2'b01) && !i_memwrite_m;
  assign access         = i_memwrite_m || (i_resultsrc_m == 2'b01);
  assign byte_off       = i_alu_result_m[1:0];
  assign aligned_access = access && !misaligned;

  // Only real memory accesses can fault; ALU ops reuse funct3 for other meanings.
  always_comb begin
    misaligned = 1'b0;
    if (access) begin
      unique case (i_f3_m[1:0])
        2'b01:   misaligned = byte_off[0];
        2'b10:   misaligned = (byte_off != 2'b00);
        default: misaligned = 1'b0;
      endcase
      if (is_load && ((i_f3_m == 3'b011) || (i_f3_m == 3'b110) || (i_f3_m == 3'b111))) begin
        misaligned = 1'b1;
      end
      if (is_store && (i_f3_m[2] || (i_f3_m == 3'b011))) begin
        misaligned = 1'b1;
      end
    end
  end

  always_comb begin
    o_dmem_req = 1'b0;
    o_stall_m  = 1'b0;
    state_d    = state_q;
    unique case (state_q)
      StIdle: begin
        if (aligned_access) begin
          o_dmem_req = 1'b1;
          o_stall_m  = 1'b1;
          state_d    = StWait;
        end
      end
      StWait: begin
        o_stall_m = !i_dmem_rvalid;
        if (i_dmem_rvalid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign o_dmem_we   = i_memwrite_m;
  assign o_dmem_addr = {i_alu_result_m[DMEM_ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    o_dmem_be    = 4'b1111;
    o_dmem_wdata = i_write_data_m;
    unique case (i_f3_m[1:0])
      2'b00: begin
        o_dmem_be    = 4'b0001 << byte_off;
        o_dmem_wdata = {(DATA_WIDTH / 8){i_write_data_m[7:0]}};
      end
      2'b01: begin
        o_dmem_be    = byte_off[1] ? 4'b1100 : 4'b0011;
        o_dmem_wdata = {(DATA_WIDTH / 16){i_write_data_m[15:0]}};
      end
      default: begin
        o_dmem_be    = 4'b1111;
        o_dmem_wdata = i_write_data_m;
      end
    endcase
  end

  always_comb begin
    ld_byte = i_dmem_rdata[7:0];
    unique case (byte_off)
      2'b00: ld_byte = i_dmem_rdata[7:0];
      2'b01: ld_byte = i_dmem_rdata[15:8];
      2'b10: ld_byte = i_dmem_rdata[23:16];
      2'b11: ld_byte = i_dmem_rdata[31:24];
      default: ld_byte = i_dmem_rdata[7:0];
    endcase
    ld_half = byte_off[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    unique case (i_f3_m)
      3'b000:  load_ext = {{(DATA_WIDTH - 8){ld_byte[7]}}, ld_byte};
      3'b001:  load_ext = {{(DATA_WIDTH - 16){ld_half[15]}}, ld_half};
      3'b100:  load_ext = {{(DATA_WIDTH - 8){1'b0}}, ld_byte};
      3'b101:  load_ext = {{(DATA_WIDTH - 16){1'b0}}, ld_half};
      default: load_ext = i_dmem_rdata;
    endcase
  end

  assign o_forward_m = (i_resultsrc_m == 2'b10) ?
                       {{(DATA_WIDTH - ADDR_WIDTH){1'b0}}, i_pc4_m} : i_alu_result_m;

  // Stall cycles insert a bubble: write enables drop, payload holds.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_regwrite_w   <= 1'b0;
      o_resultsrc_w  <= 2'b00;
      o_rd_addr_w    <= 5'd0;
      o_alu_result_w <= '0;
      o_read_data_w  <= '0;
      o_pc4_w        <= '0;
      o_misaligned_w <= 1'b0;
    end else if (o_stall_m) begin
      o_regwrite_w   <= 1'b0;
      o_misaligned_w <= 1'b0;
    end else begin
      o_regwrite_w   <= i_regwrite_m && !misaligned;
      o_misaligned_w <= misaligned;
      o_resultsrc_w  <= i_resultsrc_m;
      o_rd_addr_w    <= i_rd_addr_m;
      o_alu_result_w <= i_alu_result_m;
      o_pc4_w        <= i_pc4_m;
      o_read_data_w  <= (is_load && !misaligned) ? load_ext : '0;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: vector table plus hand-built reset and back-to-back sequences.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_m, wd_m, rdata;
  logic        rw_m, mw_m, rvalid;
  logic [1:0]  rs_m;
  logic [4:0]  rd_m;
  logic [9:0]  pc4_m;
  logic [2:0]  f3_m;

  logic        req, we, stall, rw_w, mis_w;
  logic [11:0] daddr;
  logic [3:0]  be;
  logic [31:0] wdata, fwd, alu_w, rdw;
  logic [1:0]  rs_w;
  logic [4:0]  rd_w;
  logic [9:0]  pc4_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_stage dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_alu_result_m (alu_m),
    .i_write_data_m (wd_m),
    .i_regwrite_m   (rw_m),
    .i_memwrite_m   (mw_m),
    .i_resultsrc_m  (rs_m),
    .i_rd_addr_m    (rd_m),
    .i_pc4_m        (pc4_m),
    .i_f3_m         (f3_m),
    .o_dmem_req     (req),
    .o_dmem_we      (we),
    .o_dmem_addr    (daddr),
    .o_dmem_be      (be),
    .o_dmem_wdata   (wdata),
    .i_dmem_rvalid  (rvalid),
    .i_dmem_rdata   (rdata),
    .o_stall_m      (stall),
    .o_forward_m    (fwd),
    .o_regwrite_w   (rw_w),
    .o_resultsrc_w  (rs_w),
    .o_rd_addr_w    (rd_w),
    .o_alu_result_w (alu_w),
    .o_read_data_w  (rdw),
    .o_pc4_w        (pc4_w),
    .o_misaligned_w (mis_w)
  );

  typedef struct {
    logic [31:0] alu, wd;
    logic        rw, mw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [9:0]  pc4;
    logic [2:0]  f3;
    logic [31:0] rdata;
    int          lat;
    logic        e_req;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_fwd;
    logic        e_mis, e_rw;
    logic [31:0] e_rdw;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] w, input logic r, input logic m,
                       input logic [1:0] s, input logic [4:0] d, input logic [9:0] p,
                       input logic [2:0] f);
    alu_m = a; wd_m = w; rw_m = r; mw_m = m; rs_m = s; rd_m = d; pc4_m = p; f3_m = f;
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] w, input logic r,
                              input logic m, input logic [1:0] s, input logic [4:0] d,
                              input logic [9:0] p, input logic [2:0] f, input logic [31:0] rd_val,
                              input int lat, input logic e_req, input logic [3:0] e_be,
                              input logic [31:0] e_wd, input logic [31:0] e_fwd,
                              input logic e_mis, input logic e_rw, input logic [31:0] e_rdw);
    vec_t v;
    v.alu = a; v.wd = w; v.rw = r; v.mw = m; v.rs = s; v.rd = d; v.pc4 = p; v.f3 = f;
    v.rdata = rd_val; v.lat = lat; v.e_req = e_req; v.e_be = e_be; v.e_wd = e_wd;
    v.e_fwd = e_fwd; v.e_mis = e_mis; v.e_rw = e_rw; v.e_rdw = e_rdw;
    return v;
  endfunction

  task automatic check_wb_zero(input string tag);
    chk({tag, " regwrite_w"}, {31'b0, rw_w}, 32'd0);
    chk({tag, " misaligned_w"}, {31'b0, mis_w}, 32'd0);
    chk({tag, " alu_result_w"}, alu_w, 32'd0);
    chk({tag, " read_data_w"}, rdw, 32'd0);
    chk({tag, " rd_addr_w"}, {27'b0, rd_w}, 32'd0);
    chk({tag, " resultsrc_w"}, {30'b0, rs_w}, 32'd0);
    chk({tag, " pc4_w"}, {22'b0, pc4_w}, 32'd0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge clk);
    drive(v.alu, v.wd, v.rw, v.mw, v.rs, v.rd, v.pc4, v.f3);
    #1;
    chk({t, " req"}, {31'b0, req}, {31'b0, v.e_req});
    chk({t, " stall"}, {31'b0, stall}, {31'b0, v.e_req});
    chk({t, " forward"}, fwd, v.e_fwd);
    if (v.e_req) begin
      chk({t, " we"}, {31'b0, we}, {31'b0, v.mw});
      chk({t, " addr"}, {20'b0, daddr}, v.alu & 32'h0000_0FFC);
      if (v.mw) begin
        chk({t, " be"}, {28'b0, be}, {28'b0, v.e_be});
        chk({t, " wdata"}, wdata, v.e_wd);
      end
      for (int k = 1; k <= v.lat; k++) begin
        @(posedge clk);
        @(negedge clk);
        if (k < v.lat) begin
          #1;
          chk({t, " wait stall"}, {31'b0, stall}, 32'd1);
          chk({t, " wait req"}, {31'b0, req}, 32'd0);
          chk({t, " bubble regwrite_w"}, {31'b0, rw_w}, 32'd0);
        end else begin
          rvalid = 1'b1;
          rdata  = v.rdata;
          #1;
          chk({t, " rvalid stall"}, {31'b0, stall}, 32'd0);
          chk({t, " rvalid req"}, {31'b0, req}, 32'd0);
        end
      end
    end
    @(posedge clk);
    #1;
    rvalid = 1'b0;
    chk({t, " regwrite_w"}, {31'b0, rw_w}, {31'b0, v.e_rw});
    chk({t, " misaligned_w"}, {31'b0, mis_w}, {31'b0, v.e_mis});
    chk({t, " alu_result_w"}, alu_w, v.alu);
    chk({t, " rd_addr_w"}, {27'b0, rd_w}, {27'b0, v.rd});
    chk({t, " resultsrc_w"}, {30'b0, rs_w}, {30'b0, v.rs});
    chk({t, " pc4_w"}, {22'b0, pc4_w}, {22'b0, v.pc4});
    if (!v.e_mis) chk({t, " read_data_w"}, rdw, v.e_rdw);
  endtask

  initial begin
    int          cnt;
    logic [31:0] mem_word;

    // alu wd rw mw rs rd pc4 f3 rdata lat | req be wd fwd mis rw rdw
    vecs.push_back(mk(32'h1234, 0, 1, 0, 2'b00, 5, 10'h040, 3'b000, 0, 0,
                      0, 4'h0, 0, 32'h1234, 0, 1, 0));
    vecs.push_back(mk(32'hDEAD_0000, 0, 1, 0, 2'b10, 1, 10'h3FC, 3'b000, 0, 0,
                      0, 4'h0, 0, 32'h0000_03FC, 0, 1, 0));
    vecs.push_back(mk(32'h103, 0, 1, 0, 2'b01, 7, 10'h044, 3'b000, 32'h80FF_00AA, 2,
                      1, 4'h0, 0, 32'h103, 0, 1, 32'hFFFF_FF80));
    vecs.push_back(mk(32'h103, 0, 1, 0, 2'b01, 7, 10'h048, 3'b100, 32'h80FF_00AA, 1,
                      1, 4'h0, 0, 32'h103, 0, 1, 32'h0000_0080));
    vecs.push_back(mk(32'h102, 0, 1, 0, 2'b01, 8, 10'h04C, 3'b001, 32'h80FF_00AA, 3,
                      1, 4'h0, 0, 32'h102, 0, 1, 32'hFFFF_80FF));
    vecs.push_back(mk(32'h000, 0, 1, 0, 2'b01, 9, 10'h050, 3'b101, 32'h1234_8765, 1,
                      1, 4'h0, 0, 32'h000, 0, 1, 32'h0000_8765));
    vecs.push_back(mk(32'h010, 0, 1, 0, 2'b01, 10, 10'h054, 3'b010, 32'hCAFE_F00D, 1,
                      1, 4'h0, 0, 32'h010, 0, 1, 32'hCAFE_F00D));
    vecs.push_back(mk(32'h001, 0, 1, 0, 2'b01, 11, 10'h058, 3'b000, 32'h1122_7344, 1,
                      1, 4'h0, 0, 32'h001, 0, 1, 32'h0000_0073));
    vecs.push_back(mk(32'h006, 32'h0000_BEEF, 0, 1, 2'b00, 0, 10'h05C, 3'b001, 0, 1,
                      1, 4'b1100, 32'hBEEF_BEEF, 32'h006, 0, 0, 0));
    vecs.push_back(mk(32'h00D, 32'h1234_56A5, 0, 1, 2'b00, 0, 10'h060, 3'b000, 0, 2,
                      1, 4'b0010, 32'hA5A5_A5A5, 32'h00D, 0, 0, 0));
    vecs.push_back(mk(32'h020, 32'h0102_0304, 0, 1, 2'b00, 0, 10'h064, 3'b010, 0, 1,
                      1, 4'b1111, 32'h0102_0304, 32'h020, 0, 0, 0));
    vecs.push_back(mk(32'h00A, 0, 1, 0, 2'b01, 9, 10'h068, 3'b010, 0, 0,
                      0, 4'h0, 0, 32'h00A, 1, 0, 0));
    vecs.push_back(mk(32'h00A, 0, 1, 0, 2'b00, 3, 10'h06C, 3'b010, 0, 0,
                      0, 4'h0, 0, 32'h00A, 0, 1, 0));
    vecs.push_back(mk(32'h001, 0, 1, 0, 2'b01, 4, 10'h070, 3'b001, 0, 0,
                      0, 4'h0, 0, 32'h001, 1, 0, 0));
    vecs.push_back(mk(32'h022, 32'h55, 0, 1, 2'b00, 0, 10'h074, 3'b010, 0, 0,
                      0, 4'h0, 0, 32'h022, 1, 0, 0));
    vecs.push_back(mk(32'h000, 0, 1, 0, 2'b01, 6, 10'h078, 3'b011, 0, 0,
                      0, 4'h0, 0, 32'h000, 1, 0, 0));
    vecs.push_back(mk(32'h000, 32'h77, 0, 1, 2'b00, 0, 10'h07C, 3'b100, 0, 0,
                      0, 4'h0, 0, 32'h000, 1, 0, 0));
    vecs.push_back(mk(32'h000, 32'h77, 0, 1, 2'b00, 0, 10'h080, 3'b011, 0, 0,
                      0, 4'h0, 0, 32'h000, 1, 0, 0));
    vecs.push_back(mk(32'h003, 32'h0000_00C3, 0, 1, 2'b00, 0, 10'h084, 3'b000, 0, 1,
                      1, 4'b1000, 32'hC3C3_C3C3, 32'h003, 0, 0, 0));
    vecs.push_back(mk(32'h002, 0, 1, 0, 2'b01, 13, 10'h088, 3'b101, 32'h80FF_00AA, 1,
                      1, 4'h0, 0, 32'h002, 0, 1, 32'h0000_80FF));

    rst_n  = 1'b0;
    rvalid = 1'b0;
    rdata  = '0;
    drive(0, 0, 0, 0, 2'b00, 0, 0, 3'b000);
    repeat (2) @(negedge clk);
    #1;
    check_wb_zero("reset");
    chk("reset stall", {31'b0, stall}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // rvalid while idle must not disturb a plain ALU op.
    @(negedge clk);
    drive(32'h55AA, 0, 1, 0, 2'b00, 14, 10'h100, 3'b000);
    rvalid = 1'b1;
    rdata  = 32'hFFFF_FFFF;
    #1;
    chk("idle rvalid stall", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1;
    rvalid = 1'b0;
    chk("idle rvalid regwrite_w", {31'b0, rw_w}, 32'd1);
    chk("idle rvalid read_data_w", rdw, 32'd0);
    chk("idle rvalid alu_result_w", alu_w, 32'h55AA);

    // Back-to-back SW then LW, memory responds one cycle after each request.
    cnt      = 0;
    mem_word = '0;
    @(negedge clk);
    drive(32'h010, 32'hA5C3_0F96, 0, 1, 2'b00, 0, 10'h104, 3'b010);
    #1;
    if (req) begin
      cnt++;
      if (we) mem_word = wdata;
    end
    chk("b2b sw stall", {31'b0, stall}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rvalid = 1'b1;
    #1;
    chk("b2b sw ack stall", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1;
    rvalid = 1'b0;
    @(negedge clk);
    drive(32'h010, 0, 1, 0, 2'b01, 12, 10'h108, 3'b010);
    #1;
    if (req) cnt++;
    chk("b2b lw stall", {31'b0, stall}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rvalid = 1'b1;
    rdata  = mem_word;
    #1;
    chk("b2b lw ack stall", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1;
    rvalid = 1'b0;
    chk("b2b lw read_data_w", rdw, 32'hA5C3_0F96);
    chk("b2b lw rd_addr_w", {27'b0, rd_w}, 32'd12);
    chk("b2b lw regwrite_w", {31'b0, rw_w}, 32'd1);
    chk("b2b req pulses", cnt, 32'd2);

    // Reset while waiting abandons the access; a late rvalid is ignored.
    @(negedge clk);
    drive(32'h010, 0, 1, 0, 2'b01, 4, 10'h10C, 3'b010);
    #1;
    chk("rst-wait req", {31'b0, req}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_wb_zero("rst-wait");
    drive(0, 0, 0, 0, 2'b00, 0, 0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-reset stall", {31'b0, stall}, 32'd0);
    chk("post-reset req", {31'b0, req}, 32'd0);
    @(negedge clk);
    rvalid = 1'b1;
    rdata  = 32'hDEAD_BEEF;
    #1;
    chk("late rvalid stall", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1;
    rvalid = 1'b0;
    check_wb_zero("late rvalid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
